// File: rtl/tag_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tag_ram_ctrl
//
// Controller and arbiter for a single-port tag RAM with synchronous read. The
// RAM is outside this block. Three clients share the RAM:
//   - lookup : reads one entry and compares it against a tag (hit/miss)
//   - update : writes {valid, tag} to one entry in a single cycle
//   - flush  : invalidates every entry, one write per cycle
//
// In IDLE, a pending flush wins over everything else. Otherwise lookup and
// update are arbitrated round-robin.
//
// Parameters
//   AWIDTH      tag RAM address width (DEPTH = 1 << AWIDTH)
//   DWIDTH      tag RAM word width; MSB = valid, the remaining bits = tag
//
// Ports
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   lk_req/lk_index/lk_tag  lookup request, held until lk_ack
//   lk_ack                  combinational grant; index and tag sampled here
//   lk_done/lk_hit          registered result pulse, 2 edges after the ack
//   up_req/up_index/up_tag/up_valid  update request, held until up_ack
//   up_ack                  combinational grant; the write happens on this edge
//   flush_req               1-cycle pulse requesting a full invalidate
//   flush_busy/flush_done   flush in progress / 1-cycle completion pulse
//   ram_addr/ram_din/ram_we RAM command
//   ram_dout                RAM read data, valid the cycle after the address
//
// Build option
//   TAG_RAM_CTRL_RESET_FLUSH_EN : when defined, reset enters FLUSH, so the RAM
//   is invalidated automatically after reset. When undefined, reset enters IDLE.
// -----------------------------------------------------------------------------
module tag_ram_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              lk_req,
  input  logic [AWIDTH-1:0] lk_index,
  input  logic [DWIDTH-2:0] lk_tag,
  output logic              lk_ack,
  output logic              lk_done,
  output logic              lk_hit,
  input  logic              up_req,
  input  logic [AWIDTH-1:0] up_index,
  input  logic [DWIDTH-2:0] up_tag,
  input  logic              up_valid,
  output logic              up_ack,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    FLUSH = 2'd2
  } state_t;

`ifdef TAG_RAM_CTRL_RESET_FLUSH_EN
  localparam state_t RESET_STATE = FLUSH;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  localparam logic [AWIDTH-1:0] LAST_INDEX = {AWIDTH{1'b1}};

  state_t            state;
  logic [AWIDTH-1:0] flush_cnt;
  logic              flush_pend;
  logic              rr_last;      // 0: lookup granted last, 1: update granted last
  logic [AWIDTH-1:0] index_p1;
  logic [DWIDTH-2:0] tag_p1;
  logic              grant_lk;
  logic              grant_up;
  logic              hit;

  // Grants are suppressed during reset, so no requester sees an ack for a
  // write that ram_we would block.
  always_comb begin
    grant_lk = 1'b0;
    grant_up = 1'b0;
    if (reset_n && (state == IDLE) && !flush_pend) begin
      grant_lk = lk_req && (!up_req || rr_last);
      grant_up = up_req && (!lk_req || !rr_last);
    end
  end

  always_comb begin
    lk_ack   = grant_lk;
    up_ack   = grant_up;
    ram_we   = 1'b0;
    ram_din  = '0;
    ram_addr = lk_index;
    case (state)
      IDLE: begin
        if (grant_up) begin
          ram_addr = up_index;
          ram_din  = {up_valid, up_tag};
          ram_we   = 1'b1;
        end
      end
      CMP:     ram_addr = index_p1;
      FLUSH: begin
        ram_addr = flush_cnt;
        ram_we   = reset_n;
      end
      default: ram_addr = lk_index;
    endcase
  end

  assign flush_busy = (state == FLUSH);
  assign hit        = ram_dout[DWIDTH-1] && (ram_dout[DWIDTH-2:0] == tag_p1);

  // Stage p0 -> p1: latch the granted lookup for the compare cycle
  always_ff @(posedge clock) begin
    if (grant_lk) begin
      index_p1 <= lk_index;
      tag_p1   <= lk_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= RESET_STATE;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      rr_last    <= 1'b0;
      lk_done    <= 1'b0;
      lk_hit     <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      lk_done    <= 1'b0;
      lk_hit     <= 1'b0;
      flush_done <= 1'b0;
      if (flush_req) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_pend) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            // A request landing on this same edge still earns its own flush.
            flush_pend <= flush_req;
          end else if (grant_lk) begin
            state   <= CMP;
            rr_last <= 1'b0;
          end else if (grant_up) begin
            rr_last <= 1'b1;
          end
        end
        // Stage p1 -> p2: RAM data is valid now; register the compare result
        CMP: begin
          lk_done <= 1'b1;
          lk_hit  <= hit;
          state   <= IDLE;
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == LAST_INDEX) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
